// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debounce.
// Drives one column low at a time, samples the rows, and reports a single accepted key.
module keypad_scanner #(
   parameter int unsigned SCAN_CYCLES    = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_press
);

   localparam int unsigned DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
   localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_KEY   = 2'd1,
      RES_MULTI = 2'd2
   } res_kind_e;

   typedef struct packed {
      res_kind_e  kind;
      logic [3:0] code;
   } frame_res_t;

   logic [3:0]       row_m;
   logic [3:0]       row_s;
   logic [1:0]       col_idx;
   logic [1:0]       col_idx_nxt_c;
   logic [DW-1:0]    dwell_cnt;
   logic [3:0][3:0]  samp;
   logic             dwell_last_c;
   logic             frame_end_c;
   logic [15:0]      bits_c;
   logic [1:0]       hits_c;
   logic [3:0]       code_c;
   frame_res_t       res_c;
   frame_res_t       cand;
   logic [CW-1:0]    deb_cnt;
   logic [CW-1:0]    deb_nxt_c;
   logic             differs_c;
   logic             accept_q;

   // Legend of the key at bit index col*4 + row.
   function automatic logic [3:0] key_lut(input logic [3:0] idx);
      logic [3:0] k;
      case (idx)
         4'd0:  k = 4'h1;
         4'd1:  k = 4'h4;
         4'd2:  k = 4'h7;
         4'd3:  k = 4'h0;
         4'd4:  k = 4'h2;
         4'd5:  k = 4'h5;
         4'd6:  k = 4'h8;
         4'd7:  k = 4'hF;
         4'd8:  k = 4'h3;
         4'd9:  k = 4'h6;
         4'd10: k = 4'h9;
         4'd11: k = 4'hE;
         4'd12: k = 4'hA;
         4'd13: k = 4'hB;
         4'd14: k = 4'hC;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Row synchronizer; resets to the idle (released) level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_m <= '1;
         row_s <= '1;
      end else begin
         row_m <= row;
         row_s <= row_m;
      end
   end

   always_comb begin
      dwell_last_c  = (dwell_cnt == DWELL_LAST);
      frame_end_c   = dwell_last_c && (col_idx == 2'd3);
      col_idx_nxt_c = col_idx + 2'd1;
   end

   // Column scan and per-column row capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_idx   <= '0;
         dwell_cnt <= '0;
         col       <= 4'b1110;
         samp      <= '0;
      end else if (dwell_last_c) begin
         samp[col_idx] <= ~row_s;
         col_idx       <= col_idx_nxt_c;
         dwell_cnt     <= '0;
         col           <= ~(4'b0001 << col_idx_nxt_c);
      end else begin
         dwell_cnt <= dwell_cnt + DW'(1);
      end
   end

   // Frame classification; column 3 is taken live as it is being stored.
   always_comb begin
      bits_c = {~row_s, samp[2], samp[1], samp[0]};
      hits_c = '0;
      code_c = '0;
      for (int i = 0; i < 16; i++) begin
         if (bits_c[i]) begin
            if (hits_c == 2'd0) code_c = key_lut(4'(i));
            if (hits_c != 2'd2) hits_c = hits_c + 2'd1;
         end
      end
      res_c = '{kind: RES_NONE, code: 4'h0};
      if (hits_c == 2'd1)      res_c = '{kind: RES_KEY, code: code_c};
      else if (hits_c == 2'd2) res_c = '{kind: RES_MULTI, code: 4'h0};
   end

   always_comb begin
      if (res_c == cand)
         deb_nxt_c = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + CW'(1);
      else
         deb_nxt_c = CW'(1);
      if (res_c.kind == RES_KEY)
         differs_c = !key_valid || (res_c.code != key_code);
      else
         differs_c = key_valid;
   end

   // Debounce: count consecutive identical frame results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cand     <= '{kind: RES_NONE, code: 4'h0};
         deb_cnt  <= '0;
         accept_q <= 1'b0;
      end else begin
         accept_q <= frame_end_c && (deb_nxt_c == DEB_MAX) && differs_c;
         if (frame_end_c) begin
            cand    <= res_c;
            deb_cnt <= deb_nxt_c;
         end
      end
   end

   // Accepted-key outputs; ghosted frames count as release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         key_press <= 1'b0;
      end else begin
         key_press <= 1'b0;
         if (accept_q) begin
            if (cand.kind == RES_KEY) begin
               key_code  <= cand.code;
               key_valid <= 1'b1;
               key_press <= 1'b1;
            end else begin
               key_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad model, vector table, and timing corner sequences.
module tb_keypad_scanner;

   localparam int unsigned SC = 4;
   localparam int unsigned DS = 3;

   // Key masks, bit index = col*4 + row
   localparam logic [15:0] K1 = 16'h0001;
   localparam logic [15:0] K4 = 16'h0002;
   localparam logic [15:0] K7 = 16'h0004;
   localparam logic [15:0] K2 = 16'h0010;
   localparam logic [15:0] K5 = 16'h0020;
   localparam logic [15:0] KF = 16'h0080;
   localparam logic [15:0] K9 = 16'h0400;
   localparam logic [15:0] KA = 16'h1000;
   localparam logic [15:0] KB = 16'h2000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_press;
   logic [15:0] keys = '0;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int dbl    = 0;
   logic prev_press = 1'b0;

   typedef struct {
      logic [15:0] keys;
      int          cycles;
      logic        exp_valid;
      logic [3:0]  exp_code;
      int          exp_presses;
      int          exp_press_at;
      int          exp_chg_at;
   } vec_t;

   vec_t vecs[14];

   keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk),
      .reset(reset),
      .row(row),
      .col(col),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_press(key_press)
   );

   always #5 clk = ~clk;

   // Passive keypad: a row is pulled low only through a pressed key on the driven column.
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4 + r] && (col[c] === 1'b0)) row[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (key_press && prev_press) dbl++;
      prev_press = key_press;
   endtask

   task automatic run_window(input logic [15:0] k, input int n,
                             output int presses, output int first_press, output int first_chg);
      logic       v0;
      logic [3:0] c0;
      keys = k;
      v0 = key_valid;
      c0 = key_code;
      presses = 0;
      first_press = -1;
      first_chg = -1;
      for (int off = 1; off <= n; off++) begin
         tick();
         if (key_press) begin
            presses++;
            if (first_press < 0) first_press = off;
         end
         if ((key_valid !== v0 || key_code !== c0) && first_chg < 0) first_chg = off;
      end
   endtask

   initial begin
      int p, fp, fc, bcnt;
      logic [3:0] one;
      logic [3:0] exp_col;
      string nm;

      vecs[0]  = '{K5,      64,  1'b1, 4'h5, 1, 49, 49};
      vecs[1]  = '{K5,      160, 1'b1, 4'h5, 0, -1, -1};
      vecs[2]  = '{16'h0,   64,  1'b0, 4'h5, 0, -1, 49};
      vecs[3]  = '{K5,      64,  1'b1, 4'h5, 1, 49, 49};
      vecs[4]  = '{16'h0,   64,  1'b0, 4'h5, 0, -1, 49};
      vecs[5]  = '{K1 | K2, 160, 1'b0, 4'h5, 0, -1, -1};
      vecs[6]  = '{16'h0,   64,  1'b0, 4'h5, 0, -1, -1};
      vecs[7]  = '{K4,      64,  1'b1, 4'h4, 1, 49, 49};
      vecs[8]  = '{K4 | K7, 64,  1'b0, 4'h4, 0, -1, 49};
      vecs[9]  = '{K4,      64,  1'b1, 4'h4, 1, 49, 49};
      vecs[10] = '{KB,      64,  1'b1, 4'hB, 1, 49, 49};
      vecs[11] = '{16'h0,   64,  1'b0, 4'hB, 0, -1, 49};
      vecs[12] = '{KF,      64,  1'b1, 4'hF, 1, 49, 49};
      vecs[13] = '{16'h0,   64,  1'b0, 4'hF, 0, -1, 49};

      // Reset state and column stepping
      repeat (3) @(posedge clk);
      #1;
      check("rst_col", 32'(col), 32'hE);
      check("rst_code", 32'(key_code), 32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_press", 32'(key_press), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      one = 4'b0001;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) tick();
         exp_col = ~(one << ((k / 4) % 4));
         $sformat(nm, "col_step%0d", k);
         check(nm, 32'(col), 32'(exp_col));
      end
      while (cyc % 16 != 0) tick();

      // Vector table, each entry starts on a frame boundary
      foreach (vecs[i]) begin
         run_window(vecs[i].keys, vecs[i].cycles, p, fp, fc);
         $sformat(nm, "vec%0d_valid", i);   check(nm, 32'(key_valid), 32'(vecs[i].exp_valid));
         $sformat(nm, "vec%0d_code", i);    check(nm, 32'(key_code), 32'(vecs[i].exp_code));
         $sformat(nm, "vec%0d_presses", i); check(nm, 32'(p), 32'(vecs[i].exp_presses));
         $sformat(nm, "vec%0d_press_at", i);check(nm, 32'(fp), 32'(vecs[i].exp_press_at));
         $sformat(nm, "vec%0d_chg_at", i);  check(nm, 32'(fc), 32'(vecs[i].exp_chg_at));
      end

      // Bounce on key A for three frames, then stable
      bcnt = 0;
      for (int m = 0; m < 48; m++) begin
         keys = (((m / 5) % 2) == 0) ? KA : 16'h0;
         tick();
         if (key_press) bcnt++;
      end
      check("bounce_no_press", 32'(bcnt), 32'h0);
      check("bounce_valid_low", 32'(key_valid), 32'h0);
      run_window(KA, 64, p, fp, fc);
      check("bounce_presses", 32'(p), 32'h1);
      check("bounce_press_at", 32'(fp), 32'd49);
      check("bounce_code", 32'(key_code), 32'hA);
      check("bounce_valid", 32'(key_valid), 32'h1);
      run_window(16'h0, 64, p, fp, fc);
      check("bounce_release", 32'(key_valid), 32'h0);

      // Asynchronous reset mid-dwell of column 2 with 9 accepted
      run_window(K9, 64, p, fp, fc);
      check("nine_valid", 32'(key_valid), 32'h1);
      check("nine_code", 32'(key_code), 32'h9);
      while (cyc % 16 != 9) tick();
      check("mid_col2", 32'(col), 32'hB);
      #2 reset = 1'b0;
      #1;
      check("async_col", 32'(col), 32'hE);
      check("async_valid", 32'(key_valid), 32'h0);
      check("async_code", 32'(key_code), 32'h0);
      check("async_press", 32'(key_press), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      prev_press = 1'b0;
      run_window(K9, 64, p, fp, fc);
      check("rearm_presses", 32'(p), 32'h1);
      check("rearm_press_at", 32'(fp), 32'd49);
      check("rearm_valid", 32'(key_valid), 32'h1);
      check("rearm_code", 32'(key_code), 32'h9);

      check("no_back_to_back", 32'(dbl), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream input stage for the connect4 game logic.
- Scans a 4x4 matrix keypad (PmodKYPD wiring) and debounces the scanned result.
- Presents a single accepted key as a 4-bit hex code (key_code, wired to keypadButton) plus a one-cycle press strobe.
- The strobe lets the game logic drop or gate a column only on a fresh key press.

Parameters:
SCAN_CYCLES, 100000, clocks each column is driven before rows are sampled; minimum 4.
DEBOUNCE_SCANS, 4, consecutive identical full-frame results required to accept a change; minimum 2.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
row  in  4  keypad row lines, active-low, externally pulled up; asynchronous to clk.
col  out  4  keypad column drives, active-low, exactly one bit low at any time.
key_code  out  4  hex legend of the last accepted key.
key_valid  out  1  high while an accepted single key is held.
key_press  out  1  one-cycle pulse when a new key is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - col=4'b1110, key_code=0, key_valid=0, key_press=0.
  - Column index, dwell counter, synchronizer, frame samples, candidate and debounce count all clear.
  - Takes effect immediately, including mid-frame. The scan restarts at column 0 on the first edge after release.
- Row input: 2-flop synchronizer, producing row_s.
- Column scan:
  - col = ~(1 << col_idx).
  - dwell_cnt counts 0..SCAN_CYCLES-1.
  - When dwell_cnt==SCAN_CYCLES-1: store ~row_s into samp[col_idx], then col_idx increments (3 wraps to 0) and dwell_cnt returns to 0.
- Frame: the four column dwells, 4*SCAN_CYCLES clocks. Frame end is the sample cycle of col_idx 3.
- Key map, as (col_idx: rows 0..3):
  - 0: 1,4,7,0
  - 1: 2,5,8,F
  - 2: 3,6,9,E
  - 3: A,B,C,D
  - Key at (r,c) is pressed when samp[c][r]=1.
- Frame result, evaluated combinationally from the 16 sample bits plus the col-3 sample being stored:
  - NONE: zero bits set.
  - KEY(code): exactly one bit set.
  - MULTI: two or more bits set (ghosting); MULTI is treated as release.
- Debounce, at each frame end:
  - If result equals cand: deb_cnt = min(deb_cnt+1, DEBOUNCE_SCANS).
  - Otherwise: cand = result and deb_cnt = 1.
  - Comparison is on the full {type, code}.
- Acceptance:
  - Condition: deb_cnt reaches DEBOUNCE_SCANS this frame end and cand differs from the accepted state.
  - Outputs update on the clock after that frame end.
  - cand=KEY(k): key_code=k, key_valid=1, key_press=1 for exactly one cycle.
  - cand=NONE/MULTI: key_valid=0, key_code holds, no pulse.
  - KEY(a) to KEY(b) directly, with no release frame between them: accepted as a new press, with a pulse and key_code=b.
- Held key: no further pulses (no auto-repeat).
- Latency from a stable press (sampled in every column): DEBOUNCE_SCANS frame ends, plus 1 clock.
- key_press is never high on two consecutive cycles. Minimum spacing is DEBOUNCE_SCANS frames.
- Counters are sized for the parameters (dwell_cnt ceil(log2(SCAN_CYCLES)) bits, deb_cnt holds DEBOUNCE_SCANS). No overflow is possible.

Test Plan:
Bench setup: SCAN_CYCLES=4, DEBOUNCE_SCANS=3 (frame = 16 clk). Keypad model drives row[r]=0 iff the pressed key is at (r,c) and col[c]==0.
1. Reset:
   - Hold reset=0 -> col=1110, key_code=0, key_valid=0, key_press=0.
   - Release -> col steps 1110, 1101, 1011, 0111, changing every 4 clk, then wraps.
2. Press "5" (row1, col1) aligned to a frame start:
   - key_press pulses exactly once, 1 clk after the 3rd frame end; key_code=5, key_valid=1.
   - Hold 10 more frames -> no further pulse.
3. Release "5" after (2):
   - key_valid=0 after the 3rd NONE frame end; key_code stays 5; no pulse.
   - Re-press "5" -> new single pulse.
4. Bounce: toggle key "A" every 5 clk for 3 frames, then hold stable:
   - No pulse while toggling.
   - Exactly one pulse, with key_code=A, after 3 fully stable frames.
5. Press "1" and "2" together from idle -> key_valid stays 0, no pulse for 10 frames. With "4" accepted, add "7" -> key_valid drops after 3 frames, no pulse.
6. Assert reset=0 mid-dwell of column 2 while "9" is accepted:
   - Outputs clear asynchronously, before the next clk edge.
   - After release with "9" still held, re-acceptance takes exactly 3 frames + 1 clk.
